led_fade_pwm: RTL and testbench

//   Downstream stage of the blinky LED state logic: takes the 1-bit LED state (TARGET) and drives a
//   pin with a PWM brightness ramp, so that on/off changes fade in and out instead of stepping.

---
 rtl/led_fade_pkg.sv | 20 ++
 rtl/led_fade_pwm_pwm_gen.sv | 46 ++++
 rtl/led_fade_pwm.sv | 146 ++++++++++++++
 tb/tb_led_fade_pwm.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/led_fade_pkg.sv
`default_nettype none
// =============================================================================
// led_fade_pkg : FSM state encoding and default parameters for led_fade_pwm
// Rev 1.0
// =============================================================================
package led_fade_pkg;

    typedef enum logic [1:0] {
        ST_OFF       = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_ON        = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } state_e;

    localparam int unsigned C_DEF_PWM_WIDTH = 8;
    localparam int unsigned C_DEF_RAMP_DIV  = 390625;
    localparam int unsigned C_DEF_STEP      = 1;

endpackage
`default_nettype wire

// File: rtl/led_fade_pwm_pwm_gen.sv
`default_nettype none
// =============================================================================
// pwm_gen : free-running PWM counter, period-aligned duty shadow and comparator
// Rev 1.0
// =============================================================================
module pwm_gen
    import led_fade_pkg::*;
#(
    parameter int unsigned PWM_WIDTH = C_DEF_PWM_WIDTH
)(
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [PWM_WIDTH-1:0] duty_in,
    output logic                 LED,
    output logic                 PERIOD
);

    localparam logic [PWM_WIDTH-1:0] C_MAX = '1;

    logic [PWM_WIDTH-1:0] cnt_q;
    logic [PWM_WIDTH-1:0] duty_q;
    logic                 led_q;
    logic                 period_q;

    // Duty is only sampled on the last count so every period uses a single value.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q    <= '0;
            duty_q   <= '0;
            led_q    <= 1'b0;
            period_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_q + 1'b1;
            if (cnt_q == C_MAX) begin
                duty_q <= duty_in;
            end
            led_q    <= (duty_q == C_MAX) || (cnt_q < duty_q);
            period_q <= (cnt_q == '0);
        end
    end

    assign LED    = led_q;
    assign PERIOD = period_q;

endmodule
`default_nettype wire

// File: rtl/led_fade_pwm.sv
`default_nettype none
// =============================================================================
// led_fade_pwm : fades an LED in/out with a PWM brightness ramp toward TARGET.
// Optional square-law duty curve when LED_FADE_GAMMA_EN is defined.
// Rev 1.0
// =============================================================================
module led_fade_pwm
    import led_fade_pkg::*;
#(
    parameter int unsigned PWM_WIDTH = C_DEF_PWM_WIDTH,
    parameter int unsigned RAMP_DIV  = C_DEF_RAMP_DIV,
    parameter int unsigned STEP      = C_DEF_STEP
)(
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 TARGET,
    output logic                 LED,
    output logic [PWM_WIDTH-1:0] LEVEL,
    output logic                 BUSY,
    output logic                 PERIOD
);

    localparam int unsigned          C_PRE_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PWM_WIDTH-1:0] C_MAX      = '1;
    localparam logic [PWM_WIDTH:0]   C_MAX_X    = {1'b0, C_MAX};
    localparam logic [PWM_WIDTH:0]   C_STEP_X   = (PWM_WIDTH+1)'(STEP);
    localparam logic [C_PRE_W-1:0]   C_PRE_LAST = C_PRE_W'(RAMP_DIV - 1);

    logic                 tgt_q;
    state_e               state_q, state_d;
    logic                 busy_q, busy_d;
    logic [PWM_WIDTH-1:0] level_q, level_d;
    logic [C_PRE_W-1:0]   pre_q, pre_d;

    logic [PWM_WIDTH:0]   w_up;
    logic [PWM_WIDTH:0]   w_dn;
    logic [PWM_WIDTH-1:0] w_level_up;
    logic [PWM_WIDTH-1:0] w_level_dn;
    logic                 w_step;
    logic [PWM_WIDTH-1:0] w_duty;

    // One extra bit catches overflow above MAX and borrow below zero.
    assign w_up       = {1'b0, level_q} + C_STEP_X;
    assign w_dn       = {1'b0, level_q} - C_STEP_X;
    assign w_level_up = (w_up > C_MAX_X) ? C_MAX : w_up[PWM_WIDTH-1:0];
    assign w_level_dn = w_dn[PWM_WIDTH] ? '0 : w_dn[PWM_WIDTH-1:0];
    assign w_step     = (pre_q == C_PRE_LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tgt_q   <= 1'b0;
            state_q <= ST_OFF;
            busy_q  <= 1'b0;
            level_q <= '0;
            pre_q   <= '0;
        end else begin
            tgt_q   <= TARGET;
            state_q <= state_d;
            busy_q  <= busy_d;
            level_q <= level_d;
            pre_q   <= pre_d;
        end
    end

    // pre_d defaults to zero, so any state change or idle state restarts the prescaler.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        pre_d   = '0;
        case (state_q)
            ST_OFF: begin
                if (tgt_q) begin
                    state_d = ST_RAMP_UP;
                end
            end
            ST_RAMP_UP: begin
                if (!tgt_q) begin
                    state_d = ST_RAMP_DOWN;
                end else if (w_step) begin
                    level_d = w_level_up;
                    if (w_level_up == C_MAX) begin
                        state_d = ST_ON;
                    end
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
            ST_ON: begin
                if (!tgt_q) begin
                    state_d = ST_RAMP_DOWN;
                end
            end
            ST_RAMP_DOWN: begin
                if (tgt_q) begin
                    state_d = ST_RAMP_UP;
                end else if (w_step) begin
                    level_d = w_level_dn;
                    if (w_level_dn == '0) begin
                        state_d = ST_OFF;
                    end
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase
        busy_d = (state_d == ST_RAMP_UP) || (state_d == ST_RAMP_DOWN);
    end

`ifdef LED_FADE_GAMMA_EN
    logic [2*PWM_WIDTH-1:0] w_sq;
    logic [PWM_WIDTH-1:0]   gam_q;

    assign w_sq = {{PWM_WIDTH{1'b0}}, level_q} * {{PWM_WIDTH{1'b0}}, level_q};

    // Full scale is pinned so the top level still drives the LED solidly on.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            gam_q <= '0;
        end else begin
            gam_q <= (level_q == C_MAX) ? C_MAX : w_sq[2*PWM_WIDTH-1:PWM_WIDTH];
        end
    end

    assign w_duty = gam_q;
`else
    assign w_duty = level_q;
`endif

    pwm_gen #(
        .PWM_WIDTH (PWM_WIDTH)
    ) u_pwm_gen (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .duty_in (w_duty),
        .LED     (LED),
        .PERIOD  (PERIOD)
    );

    assign LEVEL = level_q;
    assign BUSY  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_led_fade_pwm.sv
`default_nettype none
// =============================================================================
// tb_led_fade_pwm : directed self-checking bench for led_fade_pwm (W=4, DIV=2, STEP=1).
// Expected duty follows the square-law curve when LED_FADE_GAMMA_EN is defined.
// Rev 1.0
// =============================================================================
module tb_led_fade_pwm;

    localparam int W    = 4;
    localparam int DIV  = 2;
    localparam int STP  = 1;
    localparam int MAXV = 15;
`ifdef LED_FADE_GAMMA_EN
    localparam int DLY  = 3;
`else
    localparam int DLY  = 2;
`endif

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b0;
    logic         target = 1'b0;
    logic         led;
    logic [W-1:0] level;
    logic         busy;
    logic         period;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int hist [3];
    int dwin  = 0;
    int highs = 0;
    bit win_valid = 1'b0;

    led_fade_pwm #(
        .PWM_WIDTH (W),
        .RAMP_DIV  (DIV),
        .STEP      (STP)
    ) dut (
        .CLK    (clk),
        .RST_N  (rst_n),
        .TARGET (target),
        .LED    (led),
        .LEVEL  (level),
        .BUSY   (busy),
        .PERIOD (period)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int duty_of(input int l);
`ifdef LED_FADE_GAMMA_EN
        return (l == MAXV) ? MAXV : ((l * l) >> W);
`else
        return l;
`endif
    endfunction

    // Samples after edge k: LED reflects counter value (k-1)%16 against the duty
    // latched at the previous period boundary, i.e. from the level DLY samples back.
    task automatic step_cycle(input int exp_lvl, input int exp_busy);
        int c;
        @(posedge clk);
        #1;
        cyc++;
        c = (cyc - 1) % 16;
        if (c == 0) begin
            if (win_valid) check("highs", highs, (dwin == MAXV) ? 16 : dwin);
            dwin      = duty_of(hist[DLY-1]);
            highs     = 0;
            win_valid = 1'b1;
        end
        if (led) highs++;
        check("level",  int'(level),  exp_lvl);
        check("busy",   int'(busy),   exp_busy);
        check("period", int'(period), int'(c == 0));
        check("led",    int'(led),    int'((dwin == MAXV) || (c < dwin)));
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = exp_lvl;
    endtask

    // TARGET changes now; state follows two edges later and steps every DIV cycles.
    task automatic ramp(input bit up, input int start, input int prev_busy, input int ncyc);
        int lvl;
        int bsy;
        target = up;
        for (int n = 1; n <= ncyc; n++) begin
            if (n < 2) begin
                lvl = start;
                bsy = prev_busy;
            end else if (up) begin
                lvl = start + ((n - 2) / DIV) * STP;
                if (lvl > MAXV) lvl = MAXV;
                bsy = int'(lvl < MAXV);
            end else begin
                lvl = start - ((n - 2) / DIV) * STP;
                if (lvl < 0) lvl = 0;
                bsy = int'(lvl > 0);
            end
            step_cycle(lvl, bsy);
        end
    endtask

    task automatic clear_model();
        cyc       = 0;
        hist[0]   = 0;
        hist[1]   = 0;
        hist[2]   = 0;
        dwin      = 0;
        highs     = 0;
        win_valid = 1'b0;
    endtask

    initial begin
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        check("rst_level",  int'(level),  0);
        check("rst_led",    int'(led),    0);
        check("rst_busy",   int'(busy),   0);
        check("rst_period", int'(period), 0);
        rst_n = 1'b1;

        ramp(1'b0, 0, 0, 100);          // idle: dark, periodic PERIOD
        ramp(1'b1, 0, 0, 32 + 48);      // full fade in, then solid on
        ramp(1'b0, MAXV, 0, 32 + 48);   // full fade out, then dark
        ramp(1'b1, 0, 0, 14);           // up to level 6
        ramp(1'b0, 6, 1, 40);           // reverse without a jump
        ramp(1'b1, 0, 0, 20);           // up to level 9

        #2;
        rst_n = 1'b0;
        #1;
        check("arst_level", int'(level), 0);
        check("arst_led",   int'(led),   0);
        check("arst_busy",  int'(busy),  0);
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        check("arst_hold_level",  int'(level),  0);
        check("arst_hold_period", int'(period), 0);
        rst_n = 1'b1;
        ramp(1'b1, 0, 0, 48);           // TARGET held high: restart from 0

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
